// File: rtl/collector_ctrl_pkg.sv
// Shared definitions for the output-collector sequencer: state encoding,
// default counter widths and error-cause codes.
package collector_ctrl_pkg;

  localparam int unsigned KCNT_W_DEF = 8;
  localparam int unsigned NOUT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_ACCUM,
    ST_WAIT_RES,
    ST_OUT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CFG,
    ERR_STALL_BEAT,
    ERR_STRAY_RES
  } err_cause_e;

endpackage

// File: rtl/collector_ctrl.sv
// Output-collector sequencer: bias preload, K-beat accumulation, result wait
// and gating hand-off per output vector, plus PE-array stall control.
module collector_ctrl
  import collector_ctrl_pkg::*;
#(
  parameter int unsigned KCNT_W = KCNT_W_DEF,
  parameter int unsigned NOUT_W = NOUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [KCNT_W-1:0] cfg_k_beats,
  input  logic [NOUT_W-1:0] cfg_n_out,
  input  logic              cfg_bias_en,
  output logic              bias_req,
  input  logic              bias_ack,
  input  logic              pe_psum_valid,
  output logic              pe_stall,
  output logic              col_bias_en,
  output logic              col_bias_zero,
  output logic              col_in_valid,
  output logic              col_accum_done,
  input  logic              col_out_valid,
  output logic              gate_valid,
  input  logic              gate_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [KCNT_W-1:0] k_beats_q, k_cnt_q, k_cnt_d;
  logic [NOUT_W-1:0] n_out_q, out_cnt_q, out_cnt_d;
  logic              bias_en_q, bias_en_nx;
  logic              cfg_bad, accept, last_beat, last_vec, err_d;

  assign cfg_bad   = (cfg_k_beats == '0) || (cfg_n_out == '0);
  assign accept    = (state_q == ST_IDLE) && cfg_valid && !cfg_bad;
  assign last_beat = (k_cnt_q == k_beats_q - KCNT_W'(1));
  assign last_vec  = (out_cnt_q == n_out_q - NOUT_W'(1));

  assign cfg_ready      = (state_q == ST_IDLE);
  assign col_in_valid   = pe_psum_valid && (state_q == ST_ACCUM);
  assign col_accum_done = col_in_valid && last_beat;
  // A zero-bias BIAS visit lasts exactly one cycle, so "first BIAS cycle"
  // reduces to being in BIAS with bias disabled.
  assign col_bias_en    = (state_q == ST_BIAS) && (bias_en_q ? bias_ack : 1'b1);

  assign bias_en_nx = accept ? cfg_bias_en : bias_en_q;
  assign err_d = (pe_psum_valid && pe_stall)
              || (col_out_valid && (state_q != ST_WAIT_RES))
              || ((state_q == ST_IDLE) && cfg_valid && cfg_bad);

  always_comb begin
    state_d   = state_q;
    k_cnt_d   = k_cnt_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_BIAS;
          k_cnt_d   = '0;
          out_cnt_d = '0;
        end
      end
      ST_BIAS: begin
        if (!bias_en_q || bias_ack) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (col_in_valid) begin
          if (last_beat) begin
            k_cnt_d = '0;
            state_d = ST_WAIT_RES;
          end else begin
            k_cnt_d = k_cnt_q + KCNT_W'(1);
          end
        end
      end
      ST_WAIT_RES: begin
        if (col_out_valid) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (gate_ready) begin
          if (last_vec) begin
            state_d = ST_DONE;
          end else begin
            out_cnt_d = out_cnt_q + NOUT_W'(1);
            state_d   = ST_BIAS;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      k_cnt_q       <= '0;
      out_cnt_q     <= '0;
      k_beats_q     <= '0;
      n_out_q       <= '0;
      bias_en_q     <= 1'b0;
      bias_req      <= 1'b0;
      pe_stall      <= 1'b0;
      col_bias_zero <= 1'b0;
      gate_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_cnt_q   <= k_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (accept) begin
        k_beats_q <= cfg_k_beats;
        n_out_q   <= cfg_n_out;
        bias_en_q <= cfg_bias_en;
      end
      bias_req      <= (state_d == ST_BIAS) && bias_en_nx;
      col_bias_zero <= (state_d == ST_BIAS) && !bias_en_nx;
      pe_stall      <= state_d inside {ST_BIAS, ST_WAIT_RES, ST_OUT, ST_DONE};
      gate_valid    <= (state_d == ST_OUT);
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_collector_ctrl.sv
// Self-checking bench for collector_ctrl: behavioural job model compared every
// cycle, directed scenarios with literal event counts, then randomized jobs.
module tb_collector_ctrl;

  localparam int KW = 8;
  localparam int NW = 8;
  localparam int P_IDLE = 0, P_BIAS = 1, P_ACCUM = 2, P_WAIT = 3, P_OUT = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_bias_en = 1'b0, bias_ack = 1'b0;
  logic pe_psum_valid = 1'b0, col_out_valid = 1'b0, gate_ready = 1'b0;
  logic [KW-1:0] cfg_k_beats = '0;
  logic [NW-1:0] cfg_n_out = '0;
  logic cfg_ready, bias_req, pe_stall, col_bias_en, col_bias_zero;
  logic col_in_valid, col_accum_done, gate_valid, busy, done, err;

  collector_ctrl #(.KCNT_W(KW), .NOUT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_k_beats(cfg_k_beats), .cfg_n_out(cfg_n_out), .cfg_bias_en(cfg_bias_en),
    .bias_req(bias_req), .bias_ack(bias_ack), .pe_psum_valid(pe_psum_valid),
    .pe_stall(pe_stall), .col_bias_en(col_bias_en), .col_bias_zero(col_bias_zero),
    .col_in_valid(col_in_valid), .col_accum_done(col_accum_done),
    .col_out_valid(col_out_valid), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: where the job is, how many beats/vectors are done.
  int m_phase = P_IDLE, m_k = 0, m_n = 0, m_beat = 0, m_vec = 0;
  bit m_bias = 1'b0, m_err = 1'b0;

  // Observed-event tallies, cleared per scenario by the main process.
  int ev_req_rise, ev_ben, ev_zero_load, ev_inv, ev_acc, ev_hs, ev_done, ev_err, ev_busy, ev_gv, ev_gv_stall;
  int acc_beats[$];
  bit prev_req = 1'b0;

  always @(negedge clk) begin
    bit stall, e_inv, e_acc, e_ben, nerr;
    stall = m_phase inside {P_BIAS, P_WAIT, P_OUT, P_DONE};
    e_inv = pe_psum_valid && (m_phase == P_ACCUM);
    e_acc = e_inv && (m_beat + 1 == m_k);
    e_ben = (m_phase == P_BIAS) && (m_bias ? bias_ack : 1'b1);

    chk("cfg_ready",      cfg_ready,      m_phase == P_IDLE);
    chk("col_in_valid",   col_in_valid,   e_inv);
    chk("col_accum_done", col_accum_done, e_acc);
    chk("col_bias_en",    col_bias_en,    e_ben);
    chk("col_bias_zero",  col_bias_zero,  (m_phase == P_BIAS) && !m_bias);
    chk("bias_req",       bias_req,       (m_phase == P_BIAS) && m_bias);
    chk("pe_stall",       pe_stall,       stall);
    chk("gate_valid",     gate_valid,     m_phase == P_OUT);
    chk("busy",           busy,           m_phase != P_IDLE);
    chk("done",           done,           m_phase == P_DONE);
    chk("err",            err,            m_err);

    if (bias_req && !prev_req) ev_req_rise++;
    prev_req = bias_req;
    if (col_bias_en) ev_ben++;
    if (col_bias_en && col_bias_zero) ev_zero_load++;
    if (col_in_valid) ev_inv++;
    if (col_accum_done) begin ev_acc++; acc_beats.push_back(ev_inv); end
    if (gate_valid && gate_ready) ev_hs++;
    if (done) ev_done++;
    if (err) ev_err++;
    if (busy) ev_busy++;
    if (gate_valid) ev_gv++;
    if (gate_valid && pe_stall) ev_gv_stall++;

    nerr = (pe_psum_valid && stall) || (col_out_valid && m_phase != P_WAIT)
        || (m_phase == P_IDLE && cfg_valid && (cfg_k_beats == 0 || cfg_n_out == 0));
    if (!rst_n) begin
      m_phase = P_IDLE; m_beat = 0; m_vec = 0; m_err = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (cfg_valid && cfg_k_beats != 0 && cfg_n_out != 0) begin
          m_k = int'(cfg_k_beats); m_n = int'(cfg_n_out); m_bias = cfg_bias_en;
          m_beat = 0; m_vec = 0; m_phase = P_BIAS;
        end
        P_BIAS:  if (!m_bias || bias_ack) m_phase = P_ACCUM;
        P_ACCUM: if (e_inv) begin
          m_beat++;
          if (m_beat == m_k) begin m_beat = 0; m_phase = P_WAIT; end
        end
        P_WAIT:  if (col_out_valid) m_phase = P_OUT;
        P_OUT:   if (gate_ready) begin
          m_vec++;
          m_phase = (m_vec == m_n) ? P_DONE : P_BIAS;
        end
        default: m_phase = P_IDLE;
      endcase
      m_err = nerr;
    end
  end

  // Responder knobs: negative delay means random behaviour.
  int ack_delay = 0, cov_delay = 0, gate_delay = 0, psum_mode = 0;
  bit cov_noise = 1'b0, cfg_noise = 1'b0;
  int ph_cyc = 0, ph_prev = -1;

  always begin
    @(posedge clk); #1;
    if (m_phase == ph_prev) ph_cyc++; else ph_cyc = 0;
    ph_prev = m_phase;
    bias_ack = (ack_delay < 0) ? (($urandom % 3) == 0) : (m_phase == P_BIAS && ph_cyc == ack_delay);
    col_out_valid = (m_phase == P_WAIT && ((cov_delay < 0) ? (($urandom % 3) == 0) : (ph_cyc == cov_delay)))
                 || (cov_noise && m_phase != P_WAIT && ($urandom % 16) == 0);
    gate_ready = (gate_delay < 0) ? (($urandom % 2) == 1) : (m_phase == P_OUT && ph_cyc >= gate_delay);
    case (psum_mode)
      1: pe_psum_valid = 1'b1;
      2: pe_psum_valid = ($urandom % 2) == 1;
      3: pe_psum_valid = (m_phase == P_ACCUM);
      4: pe_psum_valid = (m_phase == P_ACCUM) || (m_phase == P_OUT);
      5: pe_psum_valid = (m_phase == P_ACCUM) && (($urandom % 2) == 1);
      default: ;
    endcase
    if (cfg_noise) begin
      cfg_valid   = (m_phase != P_IDLE) && (($urandom % 4) == 0);
      cfg_k_beats = KW'($urandom);
      cfg_n_out   = NW'($urandom);
      cfg_bias_en = ($urandom % 2) == 1;
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic clear_ev();
    ev_req_rise = 0; ev_ben = 0; ev_zero_load = 0; ev_inv = 0; ev_acc = 0; ev_hs = 0;
    ev_done = 0; ev_err = 0; ev_busy = 0; ev_gv = 0; ev_gv_stall = 0;
    acc_beats.delete();
  endtask

  task automatic start_job(input int k, input int n, input bit b);
    for (int i = 0; i < 200 && !cfg_ready; i++) cyc();
    chk("idle_wait_timeout", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_k_beats = KW'(k); cfg_n_out = NW'(n); cfg_bias_en = b;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic run_job(input int k, input int n, input bit b, input int budget);
    int d0;
    start_job(k, n, b);
    d0 = ev_done;
    for (int i = 0; i < budget && ev_done == d0; i++) cyc();
    chk("job_done_timeout", ev_done != d0, 1);
    repeat (3) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pe_stall", pe_stall, 0);
    chk("rst_gate_valid", gate_valid, 0);

    // Scenario 1: k=4 n=2 with bias, ack one cycle after req.
    ack_delay = 1; cov_delay = 2; gate_delay = 0; psum_mode = 3;
    clear_ev();
    run_job(4, 2, 1'b1, 400);
    chk("s1_bias_req_pulses", ev_req_rise, 2);
    chk("s1_bias_loads", ev_ben, 2);
    chk("s1_accum_done", ev_acc, 2);
    chk("s1_done_beat_a", acc_beats.size() > 0 ? acc_beats[0] : -1, 4);
    chk("s1_done_beat_b", acc_beats.size() > 1 ? acc_beats[1] : -1, 8);
    chk("s1_handshakes", ev_hs, 2);
    chk("s1_done", ev_done, 1);
    chk("s1_err", ev_err, 0);

    // Scenario 2: zero bias, k=3 n=1.
    clear_ev();
    run_job(3, 1, 1'b0, 200);
    chk("s2_bias_req_pulses", ev_req_rise, 0);
    chk("s2_zero_loads", ev_zero_load, 1);
    chk("s2_bias_loads", ev_ben, 1);
    chk("s2_done_beat", acc_beats.size() > 0 ? acc_beats[0] : -1, 3);

    // Scenario 3: gate_ready held low for 5 OUT cycles, psums driven in OUT.
    ack_delay = 0; gate_delay = 5; psum_mode = 4;
    clear_ev();
    run_job(2, 1, 1'b1, 200);
    chk("s3_gate_valid_cycles", ev_gv, 6);
    chk("s3_gate_valid_stalled", ev_gv_stall, 6);
    chk("s3_err_pulses", ev_err, 6);
    chk("s3_in_valid", ev_inv, 2);

    // Scenario 4: illegal descriptors.
    gate_delay = 0; psum_mode = 0; pe_psum_valid = 1'b0;
    clear_ev();
    cfg_valid = 1'b1; cfg_k_beats = '0; cfg_n_out = NW'(5); cyc();
    cfg_valid = 1'b0; cyc();
    cfg_valid = 1'b1; cfg_k_beats = KW'(3); cfg_n_out = '0; cyc();
    cfg_valid = 1'b0;
    repeat (3) cyc();
    chk("s4_err_pulses", ev_err, 2);
    chk("s4_busy_cycles", ev_busy, 0);
    chk("s4_cfg_ready", cfg_ready, 1);

    // Scenario 5: k=1 n=3.
    psum_mode = 3;
    clear_ev();
    run_job(1, 3, 1'b1, 300);
    chk("s5_accum_done", ev_acc, 3);
    chk("s5_in_valid", ev_inv, 3);
    chk("s5_handshakes", ev_hs, 3);
    chk("s5_done", ev_done, 1);

    // Scenario 6: reset mid-ACCUM with two beats taken.
    psum_mode = 0; pe_psum_valid = 1'b0;
    start_job(5, 1, 1'b0);
    for (int i = 0; i < 50 && !(busy && !pe_stall); i++) cyc();
    chk("s6_accum_wait_timeout", busy && !pe_stall, 1);
    pe_psum_valid = 1'b1; cyc(); cyc();
    pe_psum_valid = 1'b0; rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    chk("s6_busy", busy, 0);
    chk("s6_pe_stall", pe_stall, 0);
    chk("s6_cfg_ready", cfg_ready, 1);
    chk("s6_bias_zero", col_bias_zero, 0);
    psum_mode = 3;
    clear_ev();
    run_job(2, 1, 1'b0, 200);
    chk("s6_done", ev_done, 1);
    chk("s6_done_beat", acc_beats.size() > 0 ? acc_beats[0] : -1, 2);

    // Randomized jobs with noisy inputs, then the maximum counts.
    ack_delay = -1; cov_delay = -1; gate_delay = -1; psum_mode = 2;
    cov_noise = 1'b1; cfg_noise = 1'b1;
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 3), ($urandom % 2) == 1, 3000);
    clear_ev();
    run_job(255, 2, 1'b1, 5000);
    chk("max_k_accum_done", ev_acc, 2);
    chk("max_k_last_beat", acc_beats.size() > 1 ? acc_beats[1] : -1, 510);
    clear_ev();
    run_job(1, 255, 1'b0, 20000);
    chk("max_n_handshakes", ev_hs, 255);
    chk("max_n_done", ev_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collector_ctrl.md
# collector_ctrl

Sequencer for the output collector. Accepts one job descriptor (K psum beats per output vector, number of output vectors, bias enable), then runs the collector through bias preload, K-beat accumulation, result wait and hand-off to the gating module for each output vector. It also stalls the PE array while the collector is busy. Control only: the 4096-bit psum, 256-bit bias and 256-bit result buses go directly between PE array, bias buffer, collector and gating module, not through this block.

## Interface
- KCNT_W, 8: width of the K-beat count and counter.
- NOUT_W, 8: width of the output-vector count and counter.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  high in IDLE only
- cfg_k_beats  in  KCNT_W  psum beats per output vector (legal 1..2^KCNT_W-1)
- cfg_n_out  in  NOUT_W  output vectors per job (legal 1..2^NOUT_W-1)
- cfg_bias_en  in  1  preload bias (1) or zero (0)
- bias_req  out  1  request bias vector from the bias buffer
- bias_ack  in  1  bias data is valid on the collector bias bus this cycle
- pe_psum_valid  in  1  PE array psum beat
- pe_stall  out  1  PE array must not issue beats
- col_bias_en  out  1  collector loads the bias/zero into its accumulator
- col_bias_zero  out  1  collector bias mux selects 0
- col_in_valid  out  1  gated psum valid to the collector
- col_accum_done  out  1  last beat of the current vector
- col_out_valid  in  1  collector result ready
- gate_valid  out  1  result offered to the gating module
- gate_ready  in  1  gating module accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of job
- err  out  1  one-cycle pulse on a protocol error

## Operation
- States: IDLE, BIAS, ACCUM, WAIT_RES, OUT, DONE.
- IDLE:
  - cfg_valid with cfg_k_beats==0 or cfg_n_out==0: err pulses next cycle; the block stays in IDLE.
  - Otherwise: latch the descriptor, clear k_cnt and out_cnt, go to BIAS.
- BIAS:
  - If bias_en=1: bias_req=1 until bias_ack. On the bias_ack cycle, col_bias_en=1 and col_bias_zero=0.
  - If bias_en=0: in the first BIAS cycle, col_bias_en=1 and col_bias_zero=1. bias_req is never raised.
  - Either way, the block goes to ACCUM on the following edge.
- ACCUM:
  - pe_stall=0.
  - Each pe_psum_valid produces col_in_valid and increments k_cnt.
  - On the beat where k_cnt==k_beats-1: col_accum_done=1, k_cnt is cleared, next state is WAIT_RES.
- WAIT_RES: pe_stall=1. On col_out_valid, go to OUT.
- OUT:
  - pe_stall=1 and gate_valid=1 until gate_ready.
  - On the handshake: if out_cnt==n_out-1, go to DONE. Otherwise out_cnt++ and go to BIAS.
- DONE: done=1 for one cycle, then IDLE.
- Errors (err pulses one cycle; state is unaffected):
  - pe_psum_valid while pe_stall=1: the beat is dropped.
  - col_out_valid outside WAIT_RES.
- Counters are unsigned and compared for equality, so there is no wrap. The maximum legal counts exercise the full counter range.

## Timing
- Combinational outputs:
  - col_in_valid = pe_psum_valid & (state==ACCUM).
  - col_accum_done = col_in_valid & (k_cnt==k_beats-1).
  - col_bias_en = (BIAS & bias_en & bias_ack) | (BIAS first cycle & !bias_en).
  - cfg_ready = (state==IDLE).
- All other outputs are registered. Reset values: every output 0, except cfg_ready, which is 1 because the state resets to IDLE.
- pe_stall=1 in BIAS, WAIT_RES, OUT and DONE; 0 in IDLE and ACCUM.
- Cycle counts:
  - Descriptor accept to first bias_req (or zero load): 1 cycle.
  - Bias load to the first accepted psum beat: at least 1 cycle.
  - gate_valid rises the cycle after col_out_valid. Collector latency is absorbed by WAIT_RES.
- gate_valid is held stable until gate_ready; no withdrawal.
- Reset asserted in any state: on the next edge the state is IDLE, counters are 0, outputs are at reset values, and the in-flight job is abandoned.
- cfg_valid outside IDLE is ignored (cfg_ready=0).

## Structure
- Shared package: state enum, KCNT_W and NOUT_W defaults, and the error-cause encodings if later exposed.
- Single module, no sub-module. The FSM and two counters are small enough to keep inline.

## Test plan
- k=4, n=2, bias_en=1, bias_ack one cycle after req, gate_ready=1, continuous psums:
  - 2 bias_req/col_bias_en pulses.
  - col_accum_done on beats 4 and 8.
  - 2 gate handshakes, then done=1 once.
  - err never asserts.
- bias_en=0, k=3, n=1: col_bias_en with col_bias_zero=1 in the first BIAS cycle, bias_req never rises, col_accum_done on beat 3.
- gate_ready held low for 5 cycles in OUT:
  - gate_valid holds for 6 cycles and pe_stall=1.
  - No col_in_valid, even if psums are driven; each driven psum produces an err pulse.
- cfg_k_beats=0 (then cfg_n_out=0): err pulses, cfg_ready stays 1, busy stays 0.
- k=1, n=3: every accepted beat asserts col_accum_done. done follows the 3rd handshake.
- rst_n low for one cycle mid-ACCUM (k_cnt=2):
  - Next cycle: IDLE, all outputs at reset values.
  - A fresh k=2, n=1 job then completes normally.
